fpu_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one floating-point multiplier among `N_REQ` requesters. It sits between the requesting pipelines and the multiplier's start/done handshake. It selects one pending request and latches its operands, then drives the multiplier's start pulse. It waits for the level-type done signal to complete a full busy cycle and returns the result to the owner with a one-cycle valid pulse.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_mul_arbiter_if.sv | 48 ++++
 rtl/rr_pick.sv | 42 ++++
 rtl/fpu_mul_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and helpers for the floating-point multiplier arbiter.
//   arb_state_t : sequencer states
//   exp_width() : IEEE-754 exponent width for a 16/32/64-bit word
//   qnan()      : canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1)
//                 returned right-aligned in a MAX_SIZE-bit word
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int MAX_SIZE = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    RESP
  } arb_state_t;

  // 16 -> 5, 32 -> 8, 64 -> 11
  function automatic int exp_width(input int size);
    return 5 + ($clog2(size) - 4) * 3;
  endfunction

  // Exponent field plus the fraction MSB form one contiguous run of ones
  // just below the sign bit.
  function automatic logic [MAX_SIZE-1:0] qnan(input int size);
    int ew;
    ew = exp_width(size);
    return ((MAX_SIZE'(1) << (ew + 1)) - MAX_SIZE'(1)) << (size - 2 - ew);
  endfunction

endpackage

// File: rtl/fpu_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fpu_mul_arbiter_if
// Bundles the requester-side and multiplier-side signals of fpu_mul_arbiter.
//   Requester side : i_req, i_op_a, i_op_b  -> o_gnt, o_valid, o_result, o_busy
//   Multiplier side: o_mul_start, o_mul_a, o_mul_b <- i_mul_done, i_mul_result
//   o_timeout exists only when FPU_ARB_TIMEOUT_EN is defined.
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus multiplier)
// -----------------------------------------------------------------------------
interface fpu_mul_arbiter_if #(
  parameter int SIZE  = 64,
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]            i_req;
  logic [N_REQ-1:0][SIZE-1:0]  i_op_a;
  logic [N_REQ-1:0][SIZE-1:0]  i_op_b;
  logic [N_REQ-1:0]            o_gnt;
  logic [N_REQ-1:0]            o_valid;
  logic [SIZE-1:0]             o_result;
  logic                        o_busy;
  logic                        o_mul_start;
  logic [SIZE-1:0]             o_mul_a;
  logic [SIZE-1:0]             o_mul_b;
  logic                        i_mul_done;
  logic [SIZE-1:0]             i_mul_result;
`ifdef FPU_ARB_TIMEOUT_EN
  logic                        o_timeout;
`endif

  modport slave (
`ifdef FPU_ARB_TIMEOUT_EN
    output o_timeout,
`endif
    input  i_req, i_op_a, i_op_b, i_mul_done, i_mul_result,
    output o_gnt, o_valid, o_result, o_busy, o_mul_start, o_mul_a, o_mul_b
  );

  modport master (
`ifdef FPU_ARB_TIMEOUT_EN
    input  o_timeout,
`endif
    output i_req, i_op_a, i_op_b, i_mul_done, i_mul_result,
    input  o_gnt, o_valid, o_result, o_busy, o_mul_start, o_mul_a, o_mul_b
  );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req upward starting at
// last_ptr+1 with wrap-around and returns the first set bit.
//   req      : pending requests
//   last_ptr : index of the previous winner (search starts just above it)
//   gnt      : one-hot winner (all zero when nothing is pending)
//   idx      : binary index of the winner
//   any      : at least one request pending
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before the search loop, otherwise
    // paths that never match would hold the old value and infer a latch.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // i runs 1..N_REQ so the previous winner is tried last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(last_ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_mul_arbiter
// Shares one floating-point multiplier among N_REQ requesters. A round-robin
// pick in IDLE latches the winner's operands, ISSUE pulses o_gnt/o_mul_start,
// WAIT_LOW waits for the multiplier to drop done (start accepted), WAIT_DONE
// waits for done to return and captures the product, RESP pulses o_valid.
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : fpu_mul_arbiter_if.slave (requester and multiplier signals)
//
// Parameters: SIZE (word width), N_REQ (requesters), TIMEOUT_CYCLES (watchdog).
// Build option FPU_ARB_TIMEOUT_EN: adds a watchdog over the two wait states
// that ends a stuck operation with o_timeout and a quiet-NaN result.
// -----------------------------------------------------------------------------
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int SIZE           = 64,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  fpu_mul_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] valid_q, valid_d;
  logic [SIZE-1:0]  result_q, result_d;
  logic [SIZE-1:0]  mul_a_q, mul_a_d;
  logic [SIZE-1:0]  mul_b_q, mul_b_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] winner_oh;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SIZE-1:0]  QNAN  = SIZE'(qnan(SIZE));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req      (bus.i_req),
    .last_ptr (last_ptr_q),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // last_ptr always holds the current owner once an operation has started.
  assign winner_oh = N_REQ'(1) << last_ptr_q;

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    gnt_d      = '0;
    valid_d    = '0;
    start_d    = 1'b0;
    result_d   = result_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          last_ptr_d = pick_idx;
          mul_a_d    = bus.i_op_a[pick_idx];
          mul_b_d    = bus.i_op_b[pick_idx];
          gnt_d      = pick_gnt;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
      end
      // done is a level that is high while the multiplier is idle, so a low
      // level is the only proof the start was taken.
      WAIT_LOW: begin
        if (!bus.i_mul_done) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_mul_done) begin
          result_d = bus.i_mul_result;
          valid_d  = winner_oh;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FPU_ARB_TIMEOUT_EN
    if (state_q == ISSUE) cnt_d = '0;
    if (state_q == WAIT_LOW || state_q == WAIT_DONE) begin
      cnt_d = cnt_q + 1'b1;
      // A normal completion in the same cycle wins over the watchdog.
      if (cnt_q == LIMIT && !(state_q == WAIT_DONE && bus.i_mul_done)) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
        valid_d   = winner_oh;
        result_d  = QNAN;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: operand and result registers are reset as well, because they
      // drive outputs that must read zero straight out of reset.
      state_q    <= IDLE;
      last_ptr_q <= PTR_W'(N_REQ - 1);
      gnt_q      <= '0;
      valid_q    <= '0;
      result_q   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`endif

  assign bus.o_gnt       = gnt_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_result    = result_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_mul_start = start_q;
  assign bus.o_mul_a     = mul_a_q;
  assign bus.o_mul_b     = mul_b_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_mul_arbiter
// Self-checking bench for fpu_mul_arbiter (SIZE=32, N_REQ=4). Contains a
// behavioural single-precision multiplier with a programmable busy time and a
// reference round-robin model. Timeout scenario runs when FPU_ARB_TIMEOUT_EN
// is defined (TIMEOUT_CYCLES=16).
// -----------------------------------------------------------------------------
module tb_fpu_mul_arbiter;

  localparam int SIZE  = 32;
  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int LIMIT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int          ref_last;
  int          mul_busy  = 4;
  bit          mul_stuck = 1'b0;
  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [31:0] mdl_a, mdl_b;

  fpu_mul_arbiter_if #(.SIZE(SIZE), .N_REQ(N)) bus ();

  fpu_mul_arbiter #(
    .SIZE           (SIZE),
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- models
  function automatic logic [31:0] fmul32(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    logic [22:0] f;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 1;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // First pending requester strictly after 'last', wrapping around.
  function automatic int ref_pick(input logic [3:0] req, input int last);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (last + i) % N;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -2;
  endfunction

  // Multiplier: done drops on the start, stays low mul_busy cycles, then the
  // product appears with done. Reset aborts it.
  initial begin
    bus.i_mul_done   = 1'b1;
    bus.i_mul_result = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_mul_start === 1'b1) begin
        mdl_a = bus.o_mul_a;
        mdl_b = bus.o_mul_b;
        bus.i_mul_done = 1'b0;
        for (int k = 0; k < mul_busy && !rst; k++) @(negedge clk);
        while (mul_stuck && !rst) @(negedge clk);
        if (!rst) bus.i_mul_result = fmul32(mdl_a, mdl_b);
        bus.i_mul_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  // --------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      bus.i_op_a[i] = op_a[i];
      bus.i_op_b[i] = op_b[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_float();
      op_b[i] = rand_float();
    end
    load_ops();
  endtask

  task automatic wait_gnt(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (cyc < LIMIT) begin
      step();
      cyc++;
      if (bus.o_gnt !== 4'b0) begin
        idx = onehot_idx(bus.o_gnt);
        return;
      end
    end
  endtask

  task automatic wait_valid(output int idx, output logic [31:0] res,
                            output int cyc, output int extra_gnt);
    idx = -1;
    res = '0;
    cyc = 0;
    extra_gnt = 0;
    while (cyc < LIMIT) begin
      step();
      cyc++;
      if (bus.o_gnt !== 4'b0) extra_gnt++;
      if (bus.o_valid !== 4'b0) begin
        idx = onehot_idx(bus.o_valid);
        res = bus.o_result;
        return;
      end
    end
  endtask

  // One full transaction with the currently driven requests.
  task automatic serve(input string tag, input bit drop, input int busy,
                       output int gnt_cyc, output int won);
    logic [3:0]  snap;
    logic [31:0] r;
    int          exp_idx, v, vc, extra;
    snap     = bus.i_req;
    exp_idx  = ref_pick(snap, ref_last);
    mul_busy = busy;
    wait_gnt(won, gnt_cyc);
    checks++;
    if (won !== exp_idx) begin
      errors++;
      $display("FAIL %s_gnt: got requester %0d, expected %0d", tag, won, exp_idx);
    end
    if (exp_idx >= 0) begin
      checks++;
      if (bus.o_mul_start !== 1'b1 || bus.o_mul_a !== op_a[exp_idx] || bus.o_mul_b !== op_b[exp_idx]) begin
        errors++;
        $display("FAIL %s_issue: start=%b a=%h b=%h, expected start=1 a=%h b=%h",
                 tag, bus.o_mul_start, bus.o_mul_a, bus.o_mul_b, op_a[exp_idx], op_b[exp_idx]);
      end
      ref_last = exp_idx;
      wait_valid(v, r, vc, extra);
      checks++;
      if (v !== exp_idx) begin
        errors++;
        $display("FAIL %s_valid: got requester %0d, expected %0d", tag, v, exp_idx);
      end
      checks++;
      if (r !== fmul32(op_a[exp_idx], op_b[exp_idx])) begin
        errors++;
        $display("FAIL %s_result: got %h, expected %h", tag, r, fmul32(op_a[exp_idx], op_b[exp_idx]));
      end
      checks++;
      if (vc !== busy + 1 || extra !== 0) begin
        errors++;
        $display("FAIL %s_latency: valid after %0d cycles with %0d stray grants, expected %0d and 0",
                 tag, vc, extra, busy + 1);
      end
      checks++;
      if (bus.o_mul_a !== op_a[exp_idx] || bus.o_mul_b !== op_b[exp_idx]) begin
        errors++;
        $display("FAIL %s_operand_hold: a=%h b=%h at response, expected %h %h",
                 tag, bus.o_mul_a, bus.o_mul_b, op_a[exp_idx], op_b[exp_idx]);
      end
      if (drop) bus.i_req[exp_idx[1:0]] = 1'b0;
    end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    bus.i_req = '0;
    rand_ops();
    repeat (3) step();
    checks++;
    if (bus.o_gnt !== 4'b0 || bus.o_valid !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_mul_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b valid=%b busy=%b start=%b, expected all 0",
               bus.o_gnt, bus.o_valid, bus.o_busy, bus.o_mul_start);
    end
    checks++;
    if (bus.o_result !== 32'h0 || bus.o_mul_a !== 32'h0 || bus.o_mul_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: result=%h a=%h b=%h, expected all 0",
               bus.o_result, bus.o_mul_a, bus.o_mul_b);
    end
    rst = 1'b0;
    ref_last = N - 1;
    step();
  endtask

  task automatic test_single();
    int gc, won;
    op_a[0] = 32'h3FC0_0000;
    op_b[0] = 32'h4000_0000;
    load_ops();
    bus.i_req = 4'b0001;
    serve("single", 1'b1, 10, gc, won);
    checks++;
    if (gc !== 1 || won !== 0) begin
      errors++;
      $display("FAIL single_grant_time: requester %0d after %0d cycles, expected 0 after 1", won, gc);
    end
    checks++;
    if (bus.o_result !== 32'h4040_0000) begin
      errors++;
      $display("FAIL single_product: got %h, expected 40400000", bus.o_result);
    end
    step();
    checks++;
    if (bus.o_valid !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_result !== 32'h4040_0000) begin
      errors++;
      $display("FAIL single_after: valid=%b busy=%b result=%h, expected 0 0 40400000",
               bus.o_valid, bus.o_busy, bus.o_result);
    end
  endtask

  task automatic test_round_robin();
    int gc, won;
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_last = N - 1;
    rand_ops();
    bus.i_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      serve($sformatf("rr%0d", k), 1'b0, int'($urandom_range(2, 6)), gc, won);
      checks++;
      if (won !== order[k] || (k > 0 && gc !== 2)) begin
        errors++;
        $display("FAIL rr%0d_order: requester %0d after %0d cycles, expected %0d after 2",
                 k, won, gc, order[k]);
      end
    end
    bus.i_req = '0;
    repeat (2) step();
  endtask

  task automatic test_pointer_order();
    int gc, won;
    rand_ops();
    bus.i_req = 4'b0010;
    serve("ptr_setup", 1'b1, 3, gc, won);
    bus.i_req = 4'b1010;
    serve("ptr_first", 1'b1, int'($urandom_range(2, 6)), gc, won);
    checks++;
    if (won !== 3) begin
      errors++;
      $display("FAIL ptr_first_winner: got requester %0d, expected 3", won);
    end
    serve("ptr_second", 1'b1, int'($urandom_range(2, 6)), gc, won);
    checks++;
    if (won !== 1) begin
      errors++;
      $display("FAIL ptr_second_winner: got requester %0d, expected 1", won);
    end
    repeat (2) step();
  endtask

  task automatic test_mid_request();
    int g, gc, v, vc, extra, won;
    logic [31:0] r;
    rand_ops();
    mul_busy = 6;
    bus.i_req = 4'b0001;
    wait_gnt(g, gc);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL mid_gnt0: got requester %0d, expected 0", g);
    end
    ref_last = 0;
    repeat (2) step();
    bus.i_req[2] = 1'b1;
    wait_valid(v, r, vc, extra);
    checks++;
    if (v !== 0 || r !== fmul32(op_a[0], op_b[0]) || extra !== 0) begin
      errors++;
      $display("FAIL mid_resp0: requester %0d result %h stray grants %0d, expected 0 %h 0",
               v, r, extra, fmul32(op_a[0], op_b[0]));
    end
    bus.i_req[0] = 1'b0;
    serve("mid_req2", 1'b1, 3, gc, won);
    checks++;
    if (won !== 2 || gc !== 2) begin
      errors++;
      $display("FAIL mid_regrant: requester %0d after %0d cycles, expected 2 after 2", won, gc);
    end
    repeat (2) step();
  endtask

  task automatic test_drop();
    int g, gc, v, vc, extra, stray;
    logic [31:0] r;
    rand_ops();
    mul_busy = 5;
    bus.i_req = 4'b0001;
    wait_gnt(g, gc);
    ref_last = 0;
    step();
    bus.i_req[3] = 1'b1;
    step();
    bus.i_req[3] = 1'b0;
    wait_valid(v, r, vc, extra);
    bus.i_req[0] = 1'b0;
    checks++;
    if (g !== 0 || v !== 0 || r !== fmul32(op_a[0], op_b[0])) begin
      errors++;
      $display("FAIL drop_host: gnt %0d valid %0d result %h, expected 0 0 %h",
               g, v, r, fmul32(op_a[0], op_b[0]));
    end
    stray = 0;
    repeat (8) begin
      step();
      if (bus.o_gnt !== 4'b0 || bus.o_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL drop_before_grant: %0d active cycles seen, expected 0", stray);
    end
    bus.i_req = 4'b0010;
    wait_gnt(g, gc);
    bus.i_req = 4'b0000;
    ref_last = 1;
    wait_valid(v, r, vc, extra);
    checks++;
    if (g !== 1 || v !== 1 || r !== fmul32(op_a[1], op_b[1])) begin
      errors++;
      $display("FAIL drop_after_grant: gnt %0d valid %0d result %h, expected 1 1 %h",
               g, v, r, fmul32(op_a[1], op_b[1]));
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int g, gc, won, seen_valid;
    rand_ops();
    mul_busy = 10;
    bus.i_req = 4'b0001;
    wait_gnt(g, gc);
    repeat (4) step();
    checks++;
    if (g !== 0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: gnt %0d busy %b, expected 0 1", g, bus.o_busy);
    end
    rst = 1'b1;
    bus.i_req = '0;
    #1;
    checks++;
    if (bus.o_gnt !== 4'b0 || bus.o_valid !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_mul_start !== 1'b0 ||
        bus.o_result !== 32'h0 || bus.o_mul_a !== 32'h0 || bus.o_mul_b !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: gnt=%b valid=%b busy=%b start=%b result=%h a=%h b=%h, expected all 0",
               bus.o_gnt, bus.o_valid, bus.o_busy, bus.o_mul_start, bus.o_result, bus.o_mul_a, bus.o_mul_b);
    end
    seen_valid = 0;
    repeat (2) begin
      step();
      if (bus.o_valid !== 4'b0) seen_valid++;
    end
    rst = 1'b0;
    ref_last = N - 1;
    bus.i_req = 4'b1011;
    serve("rstmid_after", 1'b1, 3, gc, won);
    checks++;
    if (won !== 0 || seen_valid !== 0) begin
      errors++;
      $display("FAIL rstmid_first: requester %0d with %0d valids during reset, expected 0 and 0",
               won, seen_valid);
    end
    bus.i_req = '0;
    repeat (2) step();
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g, gc, tc;
    rand_ops();
    mul_busy  = 2;
    mul_stuck = 1'b1;
    bus.i_req = 4'b0100;
    wait_gnt(g, gc);
    ref_last = 2;
    tc = 0;
    while (tc < LIMIT) begin
      step();
      tc++;
      if (bus.o_timeout === 1'b1) break;
    end
    checks++;
    if (g !== 2 || tc !== TO + 1) begin
      errors++;
      $display("FAIL timeout_when: gnt %0d, timeout %0d cycles after grant, expected 2 and %0d", g, tc, TO + 1);
    end
    checks++;
    if (bus.o_valid !== 4'b0100 || bus.o_result !== 32'h7FC0_0000 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: valid=%b result=%h busy=%b, expected 0100 7fc00000 0",
               bus.o_valid, bus.o_result, bus.o_busy);
    end
    bus.i_req = '0;
    step();
    checks++;
    if (bus.o_timeout !== 1'b0 || bus.o_valid !== 4'b0) begin
      errors++;
      $display("FAIL timeout_pulse: timeout=%b valid=%b one cycle later, expected 0 0",
               bus.o_timeout, bus.o_valid);
    end
    mul_stuck = 1'b0;
    repeat (3) step();
  endtask
`endif

  initial begin
    bus.i_req  = '0;
    bus.i_op_a = '0;
    bus.i_op_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_order();
    test_mid_request();
    test_drop();
    test_reset_mid();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
